// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the CPU run sequencer
package cpu_ctrl_pkg;
   localparam int DW_DEF   = 32;
   localparam int NREG_DEF = 32;
   localparam int RF_AW    = 5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_RUN      = 3'd2,
      ST_DUMP_RD  = 3'd3,
      ST_DUMP_OUT = 3'd4,
      ST_DONE     = 3'd5
   } run_state_t;
endpackage

// File: rtl/cpu_dump_seq.sv
// rtl/cpu_dump_seq.sv - register scan-out: index counter, RF read capture and valid/ready output register
module cpu_dump_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_rd,
   input  logic             i_abort,
   input  logic [DW-1:0]    i_rf_rdata,
   input  logic             i_ready,
   output logic [RF_AW-1:0] o_rf_raddr,
   output logic             o_valid,
   output logic [RF_AW-1:0] o_idx,
   output logic [DW-1:0]    o_data,
   output logic             o_hs,
   output logic             o_last
);
   logic [RF_AW-1:0] r_idx;
   logic [RF_AW-1:0] r_out_idx;
   logic [DW-1:0]    r_data;
   logic             r_valid;
   logic             w_last_idx;

   assign w_last_idx = (r_idx == RF_AW'(NREG - 1));
   assign o_hs       = r_valid & i_ready;
   assign o_last     = o_hs & w_last_idx;
   assign o_rf_raddr = r_idx;
   assign o_valid    = r_valid;
   assign o_idx      = r_out_idx;
   assign o_data     = r_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx     <= '0;
         r_out_idx <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
      end else begin
         if (i_clr) begin
            r_idx <= '0;
         end else if (o_hs && !w_last_idx) begin
            r_idx <= r_idx + 1'b1;
         end
         // abort outranks a pending read so no word is offered after it
         if (i_abort) begin
            r_valid <= 1'b0;
         end else if (i_rd) begin
            r_valid <= 1'b1;
         end else if (o_hs) begin
            r_valid <= 1'b0;
         end
         if (i_rd) begin
            r_data    <= i_rf_rdata;
            r_out_idx <= r_idx;
         end
      end
   end
endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run sequencer: program load, counted CPU run, freeze and register dump
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int IM_AW = 8,
   parameter int CNT_W = 16,
   parameter int DW    = DW_DEF,
   parameter int NREG  = NREG_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [IM_AW:0]   prog_len_i,
   input  logic [CNT_W-1:0] run_cycles_i,
   input  logic             load_valid_i,
   input  logic [DW-1:0]    load_data_i,
   output logic             load_ready_o,
   output logic             im_we_o,
   output logic [IM_AW-1:0] im_addr_o,
   output logic [DW-1:0]    im_wdata_o,
   output logic             cpu_rst_n_o,
   output logic             cpu_en_o,
   output logic [RF_AW-1:0] rf_raddr_o,
   input  logic [DW-1:0]    rf_rdata_i,
   output logic             dump_valid_o,
   input  logic             dump_ready_i,
   output logic [RF_AW-1:0] dump_idx_o,
   output logic [DW-1:0]    dump_data_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam logic [IM_AW:0] IM_WORDS = {1'b1, {IM_AW{1'b0}}};

   run_state_t       r_state, w_next;
   logic [IM_AW:0]   r_len, r_wcnt, w_len_sat;
   logic [CNT_W-1:0] r_cycles, r_rcnt, w_cyc_nxt;
   logic             r_load_ready, r_cpu_rst_n, r_cpu_en, r_busy, r_done;
   logic             w_load_ready_nxt, w_cpu_rst_n_nxt, w_cpu_en_nxt, w_busy_nxt, w_done_nxt;
   logic             w_start, w_abort, w_beat, w_load_last, w_run_last;
   logic             w_hs, w_dump_last;

   assign w_abort     = abort_i && (r_state != ST_IDLE);
   assign w_start     = start_i && !w_abort && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_len_sat   = (prog_len_i > IM_WORDS) ? IM_WORDS : prog_len_i;
   assign w_cyc_nxt   = w_start ? run_cycles_i : r_cycles;
   assign w_beat      = load_valid_i & r_load_ready;
   assign w_load_last = w_beat && ((r_wcnt + 1'b1) == r_len);
   assign w_run_last  = (r_cycles == '0) || (r_rcnt == (r_cycles - 1'b1));

   assign im_we_o     = w_beat;
   assign im_addr_o   = w_beat ? r_wcnt[IM_AW-1:0] : '0;
   assign im_wdata_o  = w_beat ? load_data_i : '0;

   assign load_ready_o = r_load_ready;
   assign cpu_rst_n_o  = r_cpu_rst_n;
   assign cpu_en_o     = r_cpu_en;
   assign busy_o       = r_busy;
   assign done_o       = r_done;

   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = ST_IDLE;
      end else if (w_start) begin
         w_next = (prog_len_i == '0) ? ST_RUN : ST_LOAD;
      end else begin
         case (r_state)
            ST_LOAD:     if (w_load_last) w_next = ST_RUN;
            ST_RUN:      if (w_run_last) w_next = ST_DUMP_RD;
            ST_DUMP_RD:  w_next = ST_DUMP_OUT;
            ST_DUMP_OUT: if (w_hs) w_next = w_dump_last ? ST_DONE : ST_DUMP_RD;
            default:     w_next = r_state;
         endcase
      end
      // outputs are registered from the next state so they align with it
      w_load_ready_nxt = (w_next == ST_LOAD);
      w_cpu_rst_n_nxt  = (w_next != ST_IDLE) && (w_next != ST_LOAD);
      w_cpu_en_nxt     = (w_next == ST_RUN) && (w_cyc_nxt != '0);
      w_busy_nxt       = (w_next != ST_IDLE) && (w_next != ST_DONE);
      w_done_nxt       = (w_next == ST_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_wcnt       <= '0;
         r_cycles     <= '0;
         r_rcnt       <= '0;
         r_load_ready <= 1'b0;
         r_cpu_rst_n  <= 1'b0;
         r_cpu_en     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_load_ready <= w_load_ready_nxt;
         r_cpu_rst_n  <= w_cpu_rst_n_nxt;
         r_cpu_en     <= w_cpu_en_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         if (w_start) begin
            r_len    <= w_len_sat;
            r_cycles <= run_cycles_i;
            r_wcnt   <= '0;
            r_rcnt   <= '0;
         end else begin
            if (w_beat) r_wcnt <= r_wcnt + 1'b1;
            if (r_state == ST_RUN) r_rcnt <= r_rcnt + 1'b1;
         end
      end
   end

   cpu_dump_seq #(
      .DW   (DW),
      .NREG (NREG)
   ) u_dump (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_clr      (w_start),
      .i_rd       (r_state == ST_DUMP_RD),
      .i_abort    (w_abort),
      .i_rf_rdata (rf_rdata_i),
      .i_ready    (dump_ready_i),
      .o_rf_raddr (rf_raddr_o),
      .o_valid    (dump_valid_o),
      .o_idx      (dump_idx_o),
      .o_data     (dump_data_o),
      .o_hs       (w_hs),
      .o_last     (w_dump_last)
   );
endmodule
